// File: rtl/lab4_pkg.sv
// ---------------------------------------------------------------------------
// lab4_pkg
// Shared definitions for the single-step / free-run controller.
//   ctrl_state_t : controller state encoding, also shown on the hex display
//   is_halted()  : decode of the states in which the CPU is not advancing
// ---------------------------------------------------------------------------
package lab4_pkg;

    typedef enum logic [1:0] {
        S_HALT      = 2'd0,
        S_RUN       = 2'd1,
        S_STEP_HOLD = 2'd2,
        S_BREAK     = 2'd3
    } ctrl_state_t;

    localparam int STEP_COUNT_W = 12;

    // True for the states reported to the operator as "halted".
    function automatic logic is_halted(input ctrl_state_t s);
        logic h;
        case (s)
            S_HALT:  h = 1'b1;
            S_BREAK: h = 1'b1;
            default: h = 1'b0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer followed by a counting debouncer for a pushbutton.
// A new level is accepted only after DEBOUNCE consecutive synchronized
// samples that differ from the current debounced level.
// Ports:
//   clk   : system clock (rising edge)
//   rst   : synchronous active-low reset; releases the key (level = 0)
//   key   : raw pushbutton, asynchronous to clk
//   level : debounced key level (registered)
//   rise  : one-cycle press strobe, high in the cycle whose edge loads
//           level from 0 to 1
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic rise
);

    // A counter of at least one bit keeps DEBOUNCE = 1 legal.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          diff_s;
    logic          accept_s;

    // The current sample counts toward a change only while it differs from
    // the accepted level; the DEBOUNCE-th such sample commits the change.
    assign diff_s   = (sync2_r != level_r);
    assign accept_s = diff_s && (cnt_r == CNT_MAX);

    // Synchronizer, debounce counter and accepted level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
            if (accept_s) begin
                level_r <= sync2_r;
                cnt_r   <= {CW{1'b0}};
            end else if (diff_s) begin
                cnt_r   <= cnt_r + CW'(1);
            end else begin
                cnt_r   <= {CW{1'b0}};
            end
        end
    end

    assign level = level_r;
    assign rise  = accept_s & sync2_r;

endmodule

// File: rtl/step_controller.sv
// ---------------------------------------------------------------------------
// step_controller
// Clock-enable generator for a teaching CPU: free-runs at clk/RUN_DIV,
// single-steps on a debounced pushbutton, and stops at a breakpoint address.
// Ports:
//   clk        : system clock (rising edge)
//   rst        : synchronous active-low reset
//   run_mode   : 1 = free-run, 0 = single-step
//   step_key   : raw step pushbutton, active-high, asynchronous
//   bp_en      : breakpoint enable
//   bp_addr    : breakpoint instruction address
//   pc         : current program counter from the datapath
//   en         : registered one-cycle advance pulse
//   halted     : 1 in S_HALT or S_BREAK
//   state_dbg  : current state encoding
//   step_count : en pulses since reset, wraps at 4095
// ---------------------------------------------------------------------------
module step_controller
    import lab4_pkg::*;
#(
    parameter int RUN_DIV  = 5_000_000,
    parameter int DEBOUNCE = 500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_mode,
    input  logic        step_key,
    input  logic        bp_en,
    input  logic [5:0]  bp_addr,
    input  logic [5:0]  pc,
    output logic        en,
    output logic        halted,
    output logic [1:0]  state_dbg,
    output logic [11:0] step_count
);

    localparam int DW = $clog2(RUN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

    ctrl_state_t             state_r;
    ctrl_state_t             state_next_s;
    logic                    en_r;
    logic                    en_next_s;
    logic                    halted_r;
    logic [DW-1:0]           div_r;
    logic [DW-1:0]           div_next_s;
    logic [STEP_COUNT_W-1:0] count_r;
    logic                    key_level_s;
    logic                    key_rise_s;
    logic                    tick_s;
    logic                    bp_hit_s;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_key (
        .clk   (clk),
        .rst   (rst),
        .key   (step_key),
        .level (key_level_s),
        .rise  (key_rise_s)
    );

    assign tick_s   = (div_r == DIV_MAX);
    assign bp_hit_s = bp_en && (pc == bp_addr);

    // Next state, next divider value and the pulse decision.
    always_comb begin
        state_next_s = state_r;
        en_next_s    = 1'b0;
        div_next_s   = {DW{1'b0}};
        case (state_r)
            S_HALT: begin
                if (run_mode) begin
                    state_next_s = S_RUN;
                end else if (key_rise_s) begin
                    // Single-step ignores the breakpoint.
                    en_next_s    = 1'b1;
                    state_next_s = S_STEP_HOLD;
                end else begin
                    state_next_s = S_HALT;
                end
            end
            S_RUN: begin
                // Leaving run mode wins over a coincident tick.
                if (!run_mode) begin
                    state_next_s = S_HALT;
                end else if (tick_s) begin
                    if (bp_hit_s) begin
                        state_next_s = S_BREAK;
                    end else begin
                        en_next_s    = 1'b1;
                        state_next_s = S_RUN;
                    end
                end else begin
                    div_next_s   = div_r + DW'(1);
                    state_next_s = S_RUN;
                end
            end
            S_STEP_HOLD: begin
                // Wait for release so one press gives exactly one pulse.
                if (!key_level_s) begin
                    state_next_s = S_HALT;
                end else begin
                    state_next_s = S_STEP_HOLD;
                end
            end
            S_BREAK: begin
                if (!run_mode) begin
                    state_next_s = S_HALT;
                end else if (key_rise_s) begin
                    // Step past the breakpoint, then resume free-run.
                    en_next_s    = 1'b1;
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_BREAK;
                end
            end
            default: begin
                state_next_s = S_HALT;
            end
        endcase
    end

    // State, pulse, status and step counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= S_HALT;
            en_r     <= 1'b0;
            halted_r <= 1'b1;
            div_r    <= {DW{1'b0}};
            count_r  <= {STEP_COUNT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            en_r     <= en_next_s;
            halted_r <= is_halted(state_next_s);
            div_r    <= div_next_s;
            if (en_r) begin
                count_r <= count_r + STEP_COUNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign en         = en_r;
    assign halted     = halted_r;
    assign state_dbg  = state_r;
    assign step_count = count_r;

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter RUN_DIV, default 5_000_000: clk cycles between advance pulses in run mode; legal range 2 or more.
REQ-002 SHALL have parameter DEBOUNCE, default 500_000: cycles step_key must hold a new level before it is accepted; legal range 1 or more.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port run_mode, input, 1: 1 = free-run, 0 = single-step; synchronous level.
REQ-006 SHALL have port step_key, input, 1: raw step pushbutton, active-high pressed; asynchronous to clk.
REQ-007 SHALL have port bp_en, input, 1: breakpoint enable.
REQ-008 SHALL have port bp_addr, input, 6: breakpoint instruction address.
REQ-009 SHALL have port pc, input, 6: current program-counter address from the datapath.
REQ-010 SHALL have port en, output, 1: one-cycle advance pulse to the program counter and register-file write enable.
REQ-011 SHALL have port halted, output, 1: 1 when the state is S_HALT or S_BREAK.
REQ-012 SHALL have port state_dbg, output, 2: encoding of the current state, for the hex display.
REQ-013 SHALL have port step_count, output, 12: number of en pulses issued since reset.

Function
REQ-014 SHALL pass step_key through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE consecutive equal samples.
REQ-015 SHALL treat a 0-to-1 transition of the debounced key as a press, lasting one cycle.
REQ-016 SHALL have four states: S_HALT=0, S_RUN=1, S_STEP_HOLD=2, S_BREAK=3.
REQ-017 S_HALT: if run_mode=1, go to S_RUN with the divider cleared and no pulse.
REQ-018 S_HALT: if run_mode=0 and a press occurs, assert en for exactly one cycle and go to S_STEP_HOLD; the breakpoint is ignored in step mode.
REQ-019 S_STEP_HOLD: issue no further en; go to S_HALT when the debounced key returns to 0, so each press produces exactly one pulse.
REQ-020 S_RUN: the divider counts 0..RUN_DIV-1 and wraps; a tick occurs when the divider equals RUN_DIV-1, so the first pulse comes RUN_DIV cycles after entry.
REQ-021 S_RUN tick: if bp_en=1 and pc==bp_addr, go to S_BREAK with no pulse; otherwise assert en for one cycle.
REQ-022 S_RUN: run_mode=0 goes to S_HALT on the next edge, clears the divider, and suppresses any coincident tick pulse; run_mode has priority over the tick.
REQ-023 S_BREAK: run_mode=0 goes to S_HALT.
REQ-024 S_BREAK: a press with run_mode=1 asserts en once (stepping past the breakpoint) and returns to S_RUN with the divider cleared.
REQ-025 en SHALL never be high for two consecutive cycles.
REQ-026 step_count SHALL increment on every cycle with en=1 and wrap from 4095 to 0.
REQ-027 en SHALL be registered; the output pulse is the cycle after the deciding condition.

Reset
REQ-028 When rst=0 at a clock edge, the block SHALL load: state=S_HALT, en=0, halted=1, state_dbg=0, step_count=0, divider=0, synchronizer and debouncer to the released level (0), debounce counter=0.
REQ-029 Reset asserted mid-pulse or mid-debounce SHALL abort the operation; no en is issued in the cycle after the reset edge.

Structure
REQ-030 The state enum type (ctrl_state_t) and its encodings SHALL live in shared package lab4_pkg.
REQ-031 The synchronizer and debouncer SHALL be a sub-module named key_debounce, parameterized by DEBOUNCE, with outputs level and rise.
REQ-032 The divider and debounce counters SHALL be sized with $clog2 of their parameter.

Verification (RUN_DIV=4, DEBOUNCE=3)
REQ-033 Reset, then run_mode=0 and step_key held high for 10 cycles -> exactly one en pulse, 5 cycles after the key rises; state goes S_STEP_HOLD then S_HALT after release; step_count=1.
REQ-034 step_key glitches high for 2 cycles -> no en, state stays S_HALT.
REQ-035 run_mode=1 for 17 cycles with bp_en=0 -> en pulses at 4-cycle spacing; step_count=4.
REQ-036 run_mode=1, bp_en=1, bp_addr=3, pc driven by a model of en -> after 3 pulses the state is S_BREAK, halted=1, and no en occurs while pc=3; one press -> one en, then S_RUN.
REQ-037 run_mode falls in the same cycle as a tick -> no en, state S_HALT, divider 0.
REQ-038 Force step_count=4095, then one step -> step_count=0; rst=0 during S_RUN -> all outputs reach their reset values on the next edge.
